amp_cfg_sequencer: RTL and testbench
====================================

// Module: amp_cfg_sequencer
// PURPOSE
//  Boot/config sequencer for the amplifier front end: on a send_cfg rising edge, walks a register table (reg,data pairs).
//  Issues one I2C register-write command per entry to the byte-level amp I2C master engine. Handles NACK retry and inter-write gaps.
//  Reports completion/failure. Sits between top-level control and the I2C master, which owns i2c_sda/i2c_scl.
// PARAMETERS
//  N_ENTRIES   16     table depth (entries 0..N_ENTRIES-1)
//  IDX_W       4      table index width, = clog2(N_ENTRIES)
//  DEV_ADDR    7'h2C  7-bit I2C device address for every write
//  MAX_RETRY   3      re-issues of a NACKed entry before failing (total attempts = MAX_RETRY+1)
//  GAP_CYC     500    idle cycles between consecutive commands (10 us @ 50 MHz)
// PORTS
//  clk        in   1      system clock, 50 MHz
//  reset      in   1      asynchronous, active-high reset
//  send_cfg   in   1      level; rising edge starts a sequence
//  tbl_addr   out  IDX_W  table read index
//  tbl_data   in   16     {reg[15:8],data[7:0]}, valid 1 cycle after tbl_addr; 16'hFFFF = end marker
//  cmd_valid  out  1      command request to I2C master
//  cmd_ready  in   1      I2C master accepts command
//  cmd_dev    out  7      device address (=DEV_ADDR)
//  cmd_reg    out  8      register address
//  cmd_data   out  8      write data
//  rsp_valid  in   1      1-cycle pulse: transaction finished
//  rsp_nack   in   1      qualifies rsp_valid: any byte NACKed
//  busy       out  1      sequence in progress
//  done       out  1      1-cycle pulse: sequence ended OK
//  err        out  1      sticky fail flag, cleared at next start
//  err_idx    out  IDX_W  index of failing entry (valid while err)
//  wr_count   out  IDX_W+1  entries written OK in current/last run
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; send_cfg edge detector primed to 1 (a level held high through reset does not trigger).
//  Start: send_cfg 0->1 (registered edge detect) in IDLE/DONE/FAIL -> clear err, err_idx, wr_count.
//    Next cycle: idx=0, busy=1, enter FETCH. Edges while busy are ignored.
//  FETCH: tbl_addr<=idx -> WAIT_ROM (1 cycle) -> capture tbl_data.
//    If tbl_data==16'hFFFF -> DONE; else ISSUE.
//  ISSUE: cmd_valid=1, cmd_* stable until the cmd_valid&cmd_ready cycle; cmd_valid never drops before acceptance.
//    On acceptance -> WAIT_RSP, cmd_valid=0 next cycle.
//  WAIT_RSP: on rsp_valid:
//    - ack: wr_count++, retry cnt=0.
//      If idx==N_ENTRIES-1 -> DONE; else idx++ and GAP.
//    - nack & retries<MAX_RETRY: retries++, GAP, then re-ISSUE same entry (no refetch).
//    - nack & retries==MAX_RETRY: err=1, err_idx=idx -> FAIL.
//  GAP: down-counter loads GAP_CYC-1, exits at 0 (exactly GAP_CYC cycles).
//    Then FETCH (new entry) or ISSUE (retry).
//  DONE: done=1 for one cycle, busy=0 -> IDLE. FAIL: busy=0, no done pulse -> IDLE (err held).
//  Latency: start edge -> first cmd_valid = 4 cycles (edge reg, start, FETCH, WAIT_ROM).
//  rsp_valid outside WAIT_RSP ignored; cmd_ready outside ISSUE ignored.
//  Entry 0 = 16'hFFFF: done pulse, wr_count=0, no command issued.
//  reset mid-operation: async clear; cmd_valid drops immediately; no done/err; the I2C master is reset by the same reset.
//  Widths: wr_count IDX_W+1 so full-table count N_ENTRIES fits; idx must not wrap.
// STRUCTURE
//  Shared package amp_pkg: state encoding localparams (IDLE,FETCH,WAIT_ROM,ISSUE,WAIT_RSP,GAP,DONE,FAIL), END_MARK=16'hFFFF, DEV_ADDR default.
//  Single FSM module plus gap counter; no sub-module needed.
//  Default table ROM lives in a separate amp_cfg_rom (case-based, registered output) at top level.
// TESTING
//  1 Table {0x0110,0x0222,0x0333,FFFF}, engine acks all -> 3 cmds reg/data (01,10)(02,22)(03,33), dev 2C, gaps 500 cyc, done pulse, wr_count=3.
//  2 cmd_ready held low 20 cycles in ISSUE -> cmd_valid/cmd_* stable throughout; exactly one command counted.
//  3 Entry 1 NACKs twice then acks -> entry 1 issued 3x, err=0, done, wr_count=3.
//  4 Entry 2 always NACKs (MAX_RETRY=3) -> 4 attempts, err=1, err_idx=2, wr_count=2, no done, busy=0.
//  5 Full 16-entry table, no marker -> 16 writes, done, wr_count=16; send_cfg toggled mid-run -> ignored.
//  6 reset asserted in WAIT_RSP -> cmd_valid/busy 0 same cycle; send_cfg held high across release -> no restart until next 0->1.

Source files
------------

// File: rtl/amp_cfg_sequencer_pkg.sv
// amp_cfg_sequencer_pkg: shared state encoding and constants for the amp config sequencer
package amp_cfg_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, ISSUE, WAIT_RSP, GAP, DONE, FAIL} state_t;
  localparam logic [15:0] END_MARK = 16'hFFFF;
  localparam logic [6:0] DEF_DEV_ADDR = 7'h2C;
endpackage

// File: rtl/amp_cfg_sequencer.sv
// amp_cfg_sequencer: walks a register table and issues one I2C write per entry with NACK retry and inter-write gaps
module amp_cfg_sequencer
  import amp_cfg_sequencer_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int IDX_W = 4,
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int MAX_RETRY = 3,
  parameter int GAP_CYC = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send_cfg,
  output logic [IDX_W-1:0] tbl_addr,
  input  logic [15:0]      tbl_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [6:0]       cmd_dev,
  output logic [7:0]       cmd_reg,
  output logic [7:0]       cmd_data,
  input  logic             rsp_valid,
  input  logic             rsp_nack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] err_idx,
  output logic [IDX_W:0]   wr_count
);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ENTRIES - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  state_t state, nxt;
  logic send_q, rise_r, start, last;
  logic [IDX_W-1:0] idx;
  logic [RW-1:0] retries;
  logic [GW-1:0] gap_cnt;
  logic [15:0] ent;
  assign start = rise_r && state inside {IDLE, DONE, FAIL};
  assign last = idx == LAST;
  assign tbl_addr = idx;
  assign cmd_reg = ent[15:8];
  assign cmd_data = ent[7:0];
  // state register; async reset drops cmd_valid/busy at once
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // next-state: ack advances (or finishes on the last slot), nack retries via the gap until exhausted
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, FAIL: nxt = start ? FETCH : IDLE;
      FETCH:            nxt = WAIT_ROM;
      WAIT_ROM:         nxt = tbl_data == END_MARK ? DONE : ISSUE;
      ISSUE:            nxt = cmd_ready ? WAIT_RSP : ISSUE;
      WAIT_RSP:         nxt = !rsp_valid ? WAIT_RSP :
                              !rsp_nack ? (last ? DONE : GAP) :
                              retries == RMAX ? FAIL : GAP;
      GAP:              nxt = gap_cnt != '0 ? GAP : retries == '0 ? FETCH : ISSUE;
      default:          nxt = IDLE;
    endcase
  end
  // outputs decoded from the registered state so they are glitch-free
  always_comb begin
    busy = state inside {FETCH, WAIT_ROM, ISSUE, WAIT_RSP, GAP};
    cmd_valid = state == ISSUE;
    done = state == DONE;
    cmd_dev = cmd_valid ? DEV_ADDR : '0;
  end
  // datapath: edge detect (primed high), entry capture, counters and status
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      send_q <= 1'b1;
      rise_r <= 1'b0;
      idx <= '0;
      retries <= '0;
      gap_cnt <= '0;
      ent <= '0;
      err <= 1'b0;
      err_idx <= '0;
      wr_count <= '0;
    end else begin
      send_q <= send_cfg;
      rise_r <= send_cfg & ~send_q;
      if (start) begin
        idx <= '0;
        retries <= '0;
        err <= 1'b0;
        err_idx <= '0;
        wr_count <= '0;
      end
      if (state == WAIT_ROM) ent <= tbl_data;
      if (state == WAIT_RSP && rsp_valid) begin
        gap_cnt <= GW'(GAP_CYC - 1);
        if (!rsp_nack) begin
          wr_count <= wr_count + (IDX_W + 1)'(1);
          retries <= '0;
          if (!last) idx <= idx + IDX_W'(1);
        end else if (retries == RMAX) begin
          err <= 1'b1;
          err_idx <= idx;
        end else retries <= retries + RW'(1);
      end
      if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
    end
endmodule

// File: tb/tb_amp_cfg_sequencer.sv
// tb_amp_cfg_sequencer: directed checks of the config sequencer against a table ROM and I2C engine model
module tb_amp_cfg_sequencer;
  logic clk = 0, reset = 1, send_cfg = 0;
  logic [3:0] tbl_addr;
  logic [15:0] tbl_data = '0;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_nack, busy, done, err;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_data;
  logic [3:0] err_idx;
  logic [4:0] wr_count;
  int tests = 0, fails = 0, cyc = 0, ncmd = 0, done_cnt = 0, pend = 0, rsp_lat = 3;
  bit hold_ready = 0;
  logic [15:0] tbl [16];
  int nack_left [256];
  logic [7:0] lreg [$], ldat [$], cur_reg;
  logic [6:0] ldev [$];
  int acc_t [$], rsp_t [$];

  amp_cfg_sequencer dut (
    .clk(clk), .reset(reset), .send_cfg(send_cfg), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev), .cmd_reg(cmd_reg),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .busy(busy), .done(done),
    .err(err), .err_idx(err_idx), .wr_count(wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tbl_data <= tbl[tbl_addr];
  initial forever @(posedge clk) cyc++;
  initial forever @(negedge clk) if (done) done_cnt++;

  // I2C engine model: accepts when ready, answers after rsp_lat cycles, NACKs per plan
  initial begin
    cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; cur_reg = '0;
    forever begin
      @(negedge clk);
      rsp_valid = 0; rsp_nack = 0;
      if (reset) begin
        pend = 0; cmd_ready = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            rsp_valid = 1;
            rsp_nack = nack_left[cur_reg] > 0;
            if (rsp_nack) nack_left[cur_reg]--;
            rsp_t.push_back(cyc + 1);
          end
        end
        cmd_ready = !hold_ready;
        if (cmd_valid && cmd_ready) begin
          ncmd++;
          lreg.push_back(cmd_reg); ldat.push_back(cmd_data); ldev.push_back(cmd_dev);
          acc_t.push_back(cyc + 1);
          cur_reg = cmd_reg;
          pend = rsp_lat;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ncmd = 0; done_cnt = 0;
    lreg.delete(); ldat.delete(); ldev.delete(); acc_t.delete(); rsp_t.delete();
    foreach (nack_left[i]) nack_left[i] = 0;
  endtask

  task automatic start();
    @(negedge clk) send_cfg = 0;
    @(negedge clk) send_cfg = 1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk("idle_timeout", n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic load_small();
    foreach (tbl[i]) tbl[i] = 16'hFFFF;
    tbl[0] = 16'h0110; tbl[1] = 16'h0222; tbl[2] = 16'h0333;
  endtask

  initial begin
    int n;
    load_small();
    clr();
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_tbl_addr", tbl_addr, 0);

    // 1: three acked writes, start latency, gaps, done
    start();
    repeat (3) begin @(negedge clk); chk("lat_low", cmd_valid, 0); end
    @(negedge clk); chk("lat_valid", cmd_valid, 1);
    wait_idle(5000);
    chk("t1_ncmd", ncmd, 3);
    chk("t1_r0", {ldev[0], lreg[0], ldat[0]}, {7'h2C, 8'h01, 8'h10});
    chk("t1_r1", {ldev[1], lreg[1], ldat[1]}, {7'h2C, 8'h02, 8'h22});
    chk("t1_r2", {ldev[2], lreg[2], ldat[2]}, {7'h2C, 8'h03, 8'h33});
    chk("t1_gap0", acc_t[1] - rsp_t[0], 503);
    chk("t1_gap1", acc_t[2] - rsp_t[1], 503);
    chk("t1_done", done_cnt, 1);
    chk("t1_wr_count", wr_count, 3);
    chk("t1_err", err, 0);

    // 2: back-pressure in ISSUE
    clr(); hold_ready = 1;
    start();
    n = 0;
    while (!cmd_valid && n < 50) begin @(negedge clk); n++; end
    chk("t2_valid_timeout", n < 50, 1);
    repeat (20) begin
      @(negedge clk);
      chk("t2_valid_held", cmd_valid, 1);
      chk("t2_cmd_stable", {cmd_dev, cmd_reg, cmd_data}, {7'h2C, 8'h01, 8'h10});
      chk("t2_no_accept", ncmd, 0);
    end
    hold_ready = 0;
    wait_idle(5000);
    chk("t2_ncmd", ncmd, 3);
    chk("t2_first_reg", lreg[1], 8'h02);
    chk("t2_wr_count", wr_count, 3);

    // 3: entry 1 NACKs twice then acks
    clr(); nack_left[8'h02] = 2;
    start();
    wait_idle(8000);
    chk("t3_ncmd", ncmd, 5);
    chk("t3_seq", {lreg[0], lreg[1], lreg[2], lreg[3], lreg[4]}, {8'h01, 8'h02, 8'h02, 8'h02, 8'h03});
    chk("t3_retry_gap", acc_t[2] - rsp_t[1], 501);
    chk("t3_err", err, 0);
    chk("t3_done", done_cnt, 1);
    chk("t3_wr_count", wr_count, 3);

    // 4: entry 2 always NACKs
    clr(); nack_left[8'h03] = 100;
    start();
    wait_idle(8000);
    chk("t4_ncmd", ncmd, 6);
    chk("t4_last_reg", lreg[5], 8'h03);
    chk("t4_err", err, 1);
    chk("t4_err_idx", err_idx, 2);
    chk("t4_wr_count", wr_count, 2);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("t4_err_sticky", err, 1);

    // 5: full table, no end marker, start edge mid-run ignored
    clr();
    foreach (tbl[i]) tbl[i] = {8'(8'h10 + i), 8'(8'h40 + i)};
    start();
    repeat (4) @(negedge clk);
    chk("t5_err_cleared", err, 0);
    repeat (2000) @(negedge clk);
    send_cfg = 0;
    @(negedge clk) send_cfg = 1;
    wait_idle(20000);
    chk("t5_ncmd", ncmd, 16);
    chk("t5_first", {lreg[0], ldat[0]}, 16'h1040);
    chk("t5_last", {lreg[15], ldat[15]}, 16'h1F4F);
    chk("t5_done", done_cnt, 1);
    chk("t5_wr_count", wr_count, 16);
    chk("t5_err", err, 0);

    // 6: reset during WAIT_RSP with send_cfg held high
    clr(); load_small(); rsp_lat = 20;
    start();
    n = 0;
    while (ncmd < 1 && n < 50) begin @(negedge clk); n++; end
    chk("t6_accept_timeout", n < 50, 1);
    @(negedge clk);
    chk("t6_busy_before", busy, 1);
    #2 reset = 1;
    #1;
    chk("t6_busy_async", busy, 0);
    chk("t6_valid_async", cmd_valid, 0);
    @(negedge clk) reset = 0;
    rsp_lat = 3;
    repeat (20) @(negedge clk);
    chk("t6_no_restart", busy, 0);
    chk("t6_ncmd", ncmd, 1);
    chk("t6_no_done", done_cnt, 0);
    chk("t6_no_err", err, 0);
    chk("t6_wr_count", wr_count, 0);
    start();
    wait_idle(5000);
    chk("t6_rerun_wr", wr_count, 3);
    chk("t6_rerun_done", done_cnt, 1);

    // entry 0 is the end marker: done with no command
    clr(); tbl[0] = 16'hFFFF;
    start();
    wait_idle(100);
    chk("t7_ncmd", ncmd, 0);
    chk("t7_done", done_cnt, 1);
    chk("t7_wr_count", wr_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
